vx_warp_ibuffer: RTL and testbench
==================================

Name: vx_warp_ibuffer

Overview:
- Per-issue-slot instruction buffer between decode and the scoreboard stage.
- Holds decoded instructions in one small FIFO per warp.
- Round-robin arbitrates among warps with a non-empty FIFO.
- Presents one instruction at a time on a registered valid/ready output that the scoreboard consumes. Output is stalled by the scoreboard's ready, for example on operand hazards.

Parameters:
- NUM_WARPS, 4, number of warps served by this issue slot (>=2, power of 2).
- DEPTH, 2, entries per warp FIFO (>=2, power of 2).
- DATAW, 128, width of the decoded-instruction payload (opaque to this block).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  decoded instruction valid.
- in_wid  in  clog2(NUM_WARPS)  warp id of the incoming instruction.
- in_data  in  DATAW  decoded instruction payload.
- in_ready  out  1  FIFO for in_wid has space.
- out_valid  out  1  output register holds an instruction.
- out_wid  out  clog2(NUM_WARPS)  warp id of the output instruction.
- out_data  out  DATAW  payload of the output instruction.
- out_ready  in  1  scoreboard accepts the output.
- warp_full  out  NUM_WARPS  per-warp FIFO full mask (count==DEPTH), for the warp scheduler.
- warp_empty  out  NUM_WARPS  per-warp FIFO empty mask (count==0), excluding the output register.

Behaviour:
- Reset (reset==0, asynchronous): all FIFO counts, read/write pointers, the output register valid and the round-robin pointer clear immediately.
  - out_valid=0, out_wid=0, out_data=0.
  - warp_full=0, warp_empty=all ones.
  - A reset asserted mid-operation discards all buffered and output-held instructions. No partial state survives.
- Input:
  - in_ready = (count[in_wid] < DEPTH), purely combinational from the current count.
  - There is no same-cycle pop forwarding: a full FIFO refuses input even if it pops in that cycle.
  - in fire = in_valid & in_ready. On fire, write in_data at wptr[in_wid], increment wptr (wraps modulo DEPTH), increment count.
- Arbitration:
  - load_en = ~out_valid | out_ready.
  - cand = ~warp_empty.
  - When load_en and cand!=0, grant the first set bit of cand searching from (rr_ptr+1) mod NUM_WARPS upward with wrap-around.
  - On grant g: pop FIFO g (rptr[g] increments with wrap, count[g] decrements), load out_data/out_wid, set out_valid=1, set rr_ptr=g.
  - When load_en and cand==0: out_valid becomes 0 if the output fired.
- Output holding: while out_valid & ~out_ready, out_valid, out_wid and out_data stay stable. No pop occurs and rr_ptr is unchanged.
- Latency: an instruction accepted at edge N is visible in its FIFO after N and loaded at edge N+1. out_valid is asserted in the cycle after edge N+1, so minimum 2 cycles input-to-output.
- Sustained throughput: 1 instruction per cycle when out_ready is held high.
- Simultaneous push and pop on the same warp:
  - count = count+1-1 (unchanged); pointers advance independently.
  - Allowed only when the pre-edge count was < DEPTH (in_ready rule).
- Empty FIFO with push only: the entry is not eligible for arbitration until the next cycle.
- Counts are clog2(DEPTH+1) bits wide. They never overflow or underflow because of the in_ready and cand rules.
- Per-warp ordering is strictly FIFO. There is no ordering guarantee across warps beyond round-robin fairness.
- Simulation-only assertions:
  - in fire to a full FIFO must not occur.
  - out_data must be stable while out_valid & ~out_ready.

Test Plan:
1. Reset with NUM_WARPS=4, DEPTH=2:
   - Stimulus: hold reset=0, then release; push W1 payload 0xA1.
   - Response: out_valid=0 and warp_empty=4'b1111 while in reset. out_valid rises exactly 2 cycles after the push with out_wid=1 and out_data=0xA1.
2. Full and backpressure:
   - Stimulus: out_ready=0; push W2 with 0x10, 0x11, 0x12, 0x13.
   - Response: first 0x10 moves to the output register; 0x11 and 0x12 fill FIFO 2. warp_full[2]=1 and in_ready=0 for in_wid=2, so 0x13 stalls. out_data stays at 0x10 until out_ready=1.
3. Round-robin fairness:
   - Stimulus: preload W0={0x00,0x01}, W1={0x10}, W3={0x30} with out_ready=1.
   - Response: output wid order is 0,1,3,0 with data 0x00,0x10,0x30,0x01.
4. Same-cycle push and pop:
   - Stimulus: W0 count=1 and output firing from W0 while a new W0 push arrives.
   - Response: count[0] stays 1, ordering is preserved, and back-to-back out_valid occurs with no bubble.
5. Pointer wrap:
   - Stimulus: stream 7 instructions through W3 (0x70..0x76) with random out_ready.
   - Response: all 7 appear in order and warp_empty[3]=1 at the end.
6. Mid-operation reset:
   - Stimulus: with 3 warps holding entries and out_valid=1, pulse reset=0 for 1 cycle asynchronously.
   - Response: out_valid=0 immediately, warp_empty=all ones, and no stale instruction is emitted after release.

Source files
------------

// File: rtl/vx_warp_ibuffer.sv
// vx_warp_ibuffer: per-warp instruction FIFOs with round-robin issue into a registered valid/ready output
module vx_warp_ibuffer #(
    parameter int NUM_WARPS = 4,
    parameter int DEPTH     = 2,
    parameter int DATAW     = 128
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    input  logic [$clog2(NUM_WARPS)-1:0] in_wid,
    input  logic [DATAW-1:0]             in_data,
    output logic                         in_ready,
    output logic                         out_valid,
    output logic [$clog2(NUM_WARPS)-1:0] out_wid,
    output logic [DATAW-1:0]             out_data,
    input  logic                         out_ready,
    output logic [NUM_WARPS-1:0]         warp_full,
    output logic [NUM_WARPS-1:0]         warp_empty
);
    localparam int WIDW = $clog2(NUM_WARPS);
    localparam int PTRW = $clog2(DEPTH);
    localparam int CNTW = $clog2(DEPTH + 1);

    logic [DATAW-1:0]     mem   [NUM_WARPS][DEPTH];
    logic [PTRW-1:0]      wptr  [NUM_WARPS];
    logic [PTRW-1:0]      rptr  [NUM_WARPS];
    logic [CNTW-1:0]      count [NUM_WARPS];
    logic [WIDW-1:0]      rr_ptr;
    logic [WIDW-1:0]      grant;
    logic [WIDW-1:0]      idx;
    logic                 grant_valid;
    logic                 load_en;
    logic                 push;
    logic                 pop;
    logic [NUM_WARPS-1:0] cand;

    assign in_ready = count[in_wid] < CNTW'(DEPTH);
    assign push     = in_valid & in_ready;
    assign load_en  = ~out_valid | out_ready;
    assign cand     = ~warp_empty;
    assign pop      = load_en & grant_valid;

    // Occupancy flags seen by the warp scheduler (output register not included)
    always_comb begin
        warp_full  = '0;
        warp_empty = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            warp_full[w]  = count[w] == CNTW'(DEPTH);
            warp_empty[w] = count[w] == '0;
        end
    end

    // Round-robin pick: scan downward so the warp closest after rr_ptr wins, rr_ptr itself last
    always_comb begin
        grant       = rr_ptr;
        grant_valid = 1'b0;
        idx         = '0;
        for (int i = NUM_WARPS; i >= 1; i--) begin
            idx = rr_ptr + WIDW'(i);
            if (cand[idx]) begin
                grant       = idx;
                grant_valid = 1'b1;
            end
        end
    end

    // Payload storage; contents are don't-care until counted, so no reset needed
    always_ff @(posedge clk) begin
        if (push)
            mem[in_wid][wptr[in_wid]] <= in_data;
    end

    // Per-warp pointers and counts; push and pop on one warp cancel in the count
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                wptr[w]  <= '0;
                rptr[w]  <= '0;
                count[w] <= '0;
            end
        end else begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                if (push && in_wid == WIDW'(w))
                    wptr[w] <= wptr[w] + 1'b1;
                if (pop && grant == WIDW'(w))
                    rptr[w] <= rptr[w] + 1'b1;
                count[w] <= count[w] + CNTW'(push && in_wid == WIDW'(w))
                                     - CNTW'(pop && grant == WIDW'(w));
            end
        end
    end

    // Output register and round-robin pointer; both hold while the scoreboard stalls
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_wid   <= '0;
            out_data  <= '0;
            rr_ptr    <= '0;
        end else if (load_en) begin
            out_valid <= grant_valid;
            if (grant_valid) begin
                out_wid  <= grant;
                out_data <= mem[grant][rptr[grant]];
                rr_ptr   <= grant;
            end
        end
    end

`ifndef SYNTHESIS
    a_no_push_full : assert property (@(posedge clk) disable iff (!reset)
        !(push && warp_full[in_wid]));
    a_hold_stable : assert property (@(posedge clk) disable iff (!reset)
        (out_valid && !out_ready) |=> $stable(out_data));
`endif

endmodule

// File: tb/tb_vx_warp_ibuffer.sv
// tb_vx_warp_ibuffer: scoreboard bench for vx_warp_ibuffer with NUM_WARPS=4, DEPTH=2
module tb_vx_warp_ibuffer;
    typedef struct packed {
        logic [1:0]   wid;
        logic [127:0] data;
    } ent_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic [1:0]   in_wid;
    logic [127:0] in_data;
    logic         in_ready;
    logic         out_valid;
    logic [1:0]   out_wid;
    logic [127:0] out_data;
    logic         out_ready;
    logic [3:0]   warp_full;
    logic [3:0]   warp_empty;

    ent_t       sbq[$];
    logic [1:0] exp_wid[$];
    int         n_chk = 0;
    int         n_pass = 0;
    int         n_out = 0;
    int         n_before;
    bit         push_done;

    vx_warp_ibuffer #(.NUM_WARPS(4), .DEPTH(2), .DATAW(128)) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_wid(in_wid),
        .in_data(in_data),
        .in_ready(in_ready),
        .out_valid(out_valid),
        .out_wid(out_wid),
        .out_data(out_data),
        .out_ready(out_ready),
        .warp_full(warp_full),
        .warp_empty(warp_empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] w, input logic [127:0] d);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_wid   = w;
        in_data  = d;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("push_accepted", ok, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 300; n++) begin
            if (sbq.size() == 0 && !out_valid)
                break;
            tick();
        end
        check("drain_sb_empty", sbq.size(), 0);
        check("drain_out_idle", out_valid, 0);
    endtask

    // Scoreboard: record accepted inputs, match each fired output against the oldest entry of its warp
    always @(negedge clk) begin : mon
        int hit;
        if (reset) begin
            if (in_valid && in_ready)
                sbq.push_back('{wid: in_wid, data: in_data});
            if (out_valid && out_ready) begin
                hit = -1;
                for (int i = 0; i < sbq.size(); i++)
                    if (hit < 0 && sbq[i].wid == out_wid)
                        hit = i;
                check("out_expected", hit >= 0, 1);
                if (hit >= 0) begin
                    check("out_data", out_data, sbq[hit].data);
                    sbq.delete(hit);
                end
                if (exp_wid.size() > 0)
                    check("rr_order", out_wid, exp_wid.pop_front());
                n_out++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_wid    = '0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (3) tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_wid", out_wid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_warp_empty", warp_empty, 4'hf);
        check("rst_warp_full", warp_full, 4'h0);
        reset = 1'b1;
        tick();

        // Latency: accepted at edge N, loaded at N+1
        push(2'd1, 128'hA1);
        check("lat_not_yet", out_valid, 0);
        tick();
        check("lat_valid", out_valid, 1);
        check("lat_wid", out_wid, 1);
        check("lat_data", out_data, 128'hA1);
        drain();

        // Full FIFO and output backpressure
        out_ready = 1'b0;
        push(2'd2, 128'h10);
        push(2'd2, 128'h11);
        push(2'd2, 128'h12);
        check("full_w2", warp_full[2], 1);
        check("bp_valid", out_valid, 1);
        check("bp_wid", out_wid, 2);
        in_valid = 1'b1;
        in_wid   = 2'd2;
        in_data  = 128'h13;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("full_in_ready", in_ready, 0);
            check("bp_hold_data", out_data, 128'h10);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("no_fwd_in_ready", in_ready, 0);
        push(2'd2, 128'h13);
        drain();

        // Round-robin order after rr_ptr last pointed at warp 2
        out_ready = 1'b0;
        push(2'd0, 128'h00);
        push(2'd0, 128'h01);
        push(2'd1, 128'h10);
        push(2'd3, 128'h30);
        exp_wid.push_back(2'd0);
        exp_wid.push_back(2'd1);
        exp_wid.push_back(2'd3);
        exp_wid.push_back(2'd0);
        out_ready = 1'b1;
        drain();
        check("rr_all_seen", exp_wid.size(), 0);

        // Simultaneous push and pop on warp 0 with no output bubble
        out_ready = 1'b0;
        push(2'd0, 128'h40);
        push(2'd0, 128'h41);
        out_ready = 1'b1;
        push(2'd0, 128'h42);
        check("pp_valid", out_valid, 1);
        check("pp_data", out_data, 128'h41);
        check("pp_not_empty", warp_empty[0], 0);
        check("pp_not_full", warp_full[0], 0);
        tick();
        check("pp_no_bubble", out_valid, 1);
        check("pp_data2", out_data, 128'h42);
        check("pp_empty", warp_empty[0], 1);
        drain();

        // Pointer wrap on warp 3 under random backpressure
        push_done = 1'b0;
        fork
            begin
                for (int k = 0; k < 7; k++)
                    push(2'd3, 128'h70 + 128'(k));
                push_done = 1'b1;
            end
            begin
                for (int c = 0; c < 2000 && !push_done; c++) begin
                    out_ready = 1'($urandom_range(0, 1));
                    tick();
                end
            end
        join
        out_ready = 1'b1;
        drain();
        check("wrap_w3_empty", warp_empty[3], 1);

        // Asynchronous reset mid-operation discards everything
        out_ready = 1'b0;
        push(2'd0, 128'h60);
        push(2'd0, 128'h64);
        push(2'd1, 128'h61);
        push(2'd2, 128'h62);
        check("pre_rst_valid", out_valid, 1);
        check("pre_rst_empty", warp_empty, 4'h8);
        sbq.delete();
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_out_data", out_data, 0);
        check("arst_warp_empty", warp_empty, 4'hf);
        check("arst_warp_full", warp_full, 4'h0);
        @(posedge clk);
        #1;
        reset     = 1'b1;
        out_ready = 1'b1;
        n_before  = n_out;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("stale_valid", out_valid, 0);
        end
        check("no_stale_out", n_out, n_before);
        check("post_rst_empty", warp_empty, 4'hf);
        push(2'd2, 128'h99);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
